// File: rtl/mult_seq_unit_if.sv
// ============================================================================
// Module   : mult_seq_unit_if
// Brief    : Request/result bundle for the iterative MULT/MULTU unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mult_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mult_seq_unit.sv
// ============================================================================
// Module   : mult_seq_unit
// Brief    : Shift-add multiplier producing a 2*WIDTH-bit HI/LO product.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_seq_unit_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  C_LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] a_abs_q,  a_abs_d;
  logic             neg_q,    neg_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;

  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_fixed;

  always_comb begin
    // Carry-out is kept as the extra MSB so the shift never drops a product bit.
    w_add   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, a_abs_q}) : {1'b0, acc_hi_q};
    w_prod  = {acc_hi_q, acc_lo_q};
    w_fixed = neg_q ? -w_prod : w_prod;

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    a_abs_d  = a_abs_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_abs_d  = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          acc_lo_d = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          acc_hi_d = '0;
          neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_hi_d = w_add[WIDTH:1];
        acc_lo_d = {w_add[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = w_fixed[2*WIDTH-1:WIDTH];
        lo_d    = w_fixed[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      a_abs_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      a_abs_q  <= a_abs_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_unit.sv
// ============================================================================
// Module   : tb_mult_seq_unit
// Brief    : Directed vector bench for mult_seq_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_seq_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [63:0] last_prod;

  mult_seq_unit_if #(.WIDTH(32)) bus ();

  mult_seq_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launches one op starting at the next edge, optionally pokes a second start
  // mid-CALC, and returns at #1 after the done edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input string name, input int poke);
    int   lat;
    logic busy_bad;
    logic hold_bad;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.is_signed = sgn; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_bad = 1'b0; hold_bad = 1'b0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_bad = 1'b1;
      if ({bus.hi, bus.lo} !== last_prod) hold_bad = 1'b1;
      if (lat == poke) begin
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5; bus.is_signed = 1'b0;
      end else if (lat == poke + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy"}, {63'd0, busy_bad}, 64'd0);
    check({name, " hold"}, {63'd0, hold_bad}, 64'd0);
    check({name, " busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    check({name, " hi"}, {32'd0, bus.hi}, {32'd0, ehi});
    check({name, " lo"}, {32'd0, bus.lo}, {32'd0, elo});
    last_prod = {ehi, elo};
  endtask

  initial begin
    n_checks = 0; n_errors = 0; last_prod = '0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;

    vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h00000000, 32'h0000002A, "u_7x6"};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, "u_max"};
    vecs[2] = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, "s_m3x5"};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, "s_minxmin"};
    vecs[4] = '{32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000, "s_zero"};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, "u_8x8"};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, "s_m1xm1"};
    vecs[7] = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, "u_maxx2"};
    vecs[8] = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, "s_m1x2"};
    vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000, "s_maxxmin"};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Consecutive calls start in each other's done cycle (back-to-back).
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].hi, vecs[i].lo, vecs[i].name, -1);
    end

    // A second start mid-CALC must be ignored.
    do_op(32'h1234, 32'h10, 1'b0, 32'h0, 32'h12340, "ignore_start", 10);
    @(posedge clk); #1;
    check("done_pulse", {63'd0, bus.done}, 64'd0);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);

    // Abort mid-operation.
    @(negedge clk);
    bus.a = 32'hFFFF; bus.b = 32'hFFFF; bus.is_signed = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.done) saw_done = 1'b1;
      end
      check("abort no_done", {63'd0, saw_done}, 64'd0);
    end
    last_prod = '0;
    do_op(32'd3, 32'd4, 1'b0, 32'h0, 32'h0000000C, "post_reset", -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
